// File: rtl/decoder_3to8.sv
// decoder_3to8: registered 3-to-8 one-hot decoder with enable, 1-cycle latency.
// Optional DECODER_3TO8_ACTIVE_LOW_EN inverts out (idle 8'hFF, selected bit 0).
module decoder_3to8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [2:0] a_q
);
`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE = 8'hFF;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif
    logic [7:0] dec;
    // en gates the decode so an unknown select never leaks through when disabled
    always_comb dec = en ? (8'd1 << a) : 8'd0;
    // capture decode, enable and select; reset forces the idle level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= IDLE;
            out_valid <= 1'b0;
            a_q       <= 3'd0;
        end else begin
            out       <= dec ^ IDLE;
            out_valid <= en;
            a_q       <= a;
        end
    end
endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: table-driven and random scoreboard bench for decoder_3to8.
module tb_decoder_3to8;
`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE = 8'hFF;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif
    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] a;
        logic [7:0] eo;
        logic       ev;
        logic [2:0] eq;
    } vec_t;
    typedef struct {
        logic [7:0] o;
        logic       v;
        logic [2:0] q;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] a = 3'd0;
    logic       en = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic [2:0] a_q;
    int         assertions = 0;
    int         failures = 0;
    exp_t       sb[$];
    vec_t       vt[20];

    decoder_3to8 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en),
        .out(out), .out_valid(out_valid), .a_q(a_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        assertions++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
        end
    endtask

    // drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic apply(input logic r, input logic e, input logic [2:0] av, input exp_t ex);
        exp_t got;
        @(negedge clk);
        rst_n = r;
        en = e;
        a = av;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("out", out, got.o);
        check("out_valid", {7'd0, out_valid}, {7'd0, got.v});
        check("a_q", {5'd0, a_q}, {5'd0, got.q});
        check("onehot", {7'd0, $countones(out ^ IDLE) <= 1}, 8'd1);
    endtask

    initial begin
        exp_t ex;
        logic r, e;
        logic [2:0] av;
        vt[0]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0};
        vt[2]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0};
        vt[3]  = '{1'b1, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5};
        vt[4]  = '{1'b1, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0};
        vt[5]  = '{1'b1, 1'b1, 3'd1, 8'h02, 1'b1, 3'd1};
        vt[6]  = '{1'b1, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2};
        vt[7]  = '{1'b1, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3};
        vt[8]  = '{1'b1, 1'b1, 3'd4, 8'h10, 1'b1, 3'd4};
        vt[9]  = '{1'b1, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5};
        vt[10] = '{1'b1, 1'b1, 3'd6, 8'h40, 1'b1, 3'd6};
        vt[11] = '{1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7};
        vt[12] = '{1'b1, 1'b1, 3'd6, 8'h40, 1'b1, 3'd6};
        vt[13] = '{1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 3'd6};
        vt[14] = '{1'b1, 1'b1, 3'd6, 8'h40, 1'b1, 3'd6};
        vt[15] = '{1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7};
        vt[16] = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 3'd0};
        vt[17] = '{1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7};
        vt[18] = '{1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 3'd2};
        vt[19] = '{1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 3'd7};
        for (int i = 0; i < 20; i++) begin
            ex = '{vt[i].eo ^ IDLE, vt[i].ev, vt[i].eq};
            apply(vt[i].r, vt[i].e, vt[i].a, ex);
        end
        // reset held across several cycles while select keeps changing
        for (int i = 0; i < 4; i++) begin
            av = 3'(i + 1);
            ex = '{IDLE, 1'b0, 3'd0};
            apply(1'b0, 1'b1, av, ex);
        end
        ex = '{8'h10 ^ IDLE, 1'b1, 3'd4};
        apply(1'b1, 1'b1, 3'd4, ex);
        // random stream with occasional reset
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 19) != 0);
            e = 1'($urandom_range(0, 1));
            av = 3'($urandom_range(0, 7));
            ex.o = (r && e) ? (8'd1 << av) ^ IDLE : IDLE;
            ex.v = r && e;
            ex.q = r ? av : 3'd0;
            apply(r, e, av, ex);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
